// File: rtl/dragon_length_ctrl.sv
// Dragon length-update transmitter: merges heal/hit requests, applies length limits and hit immunity.
// Optional automatic healing is compiled in with the DRAGON_REGEN_EN macro.
module dragon_length_ctrl #(
  parameter int unsigned MAX_LEN       = 7,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned REGEN_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       heal_evt,
  input  logic       hit_evt,
  output logic [1:0] lengthUpdate,
  output logic [2:0] length,
  output logic       invuln,
  output logic       dead
);

  localparam int unsigned LEN_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] INV_LOAD  = CNT_W'(INVULN_FRAMES);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_HEAL = 2'b01;
  localparam logic [1:0] CODE_HIT  = 2'b10;

  if (MAX_LEN < 1 || MAX_LEN > 7 || INVULN_FRAMES > 255 ||
      REGEN_FRAMES < 1 || REGEN_FRAMES > 255) begin : g_cfg_err
    $error("dragon_length_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         upd_q, upd_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               dead_q, dead_d;
  logic               inv_q, inv_d;
  logic               pend_heal_q, pend_heal_d;
  logic               pend_hit_q, pend_hit_d;
  logic [CNT_W-1:0]   cd_q, cd_d;
  logic               vsync_q;
  logic               vsync_rise;
  logic               clr_heal, clr_hit, cd_load;
  logic               regen_fire;

  assign vsync_rise = vsync & ~vsync_q;

  // Pulse sequencer: one code cycle followed by a quiet gap cycle.
  always_comb begin
    state_d  = state_q;
    upd_d    = CODE_NONE;
    len_d    = len_q;
    dead_d   = dead_q;
    clr_heal = 1'b0;
    clr_hit  = 1'b0;
    cd_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!dead_q) begin
          if (pend_hit_q) begin
            clr_hit = 1'b1;
            if (len_q == '0) begin
              dead_d = 1'b1;
            end else begin
              upd_d   = CODE_HIT;
              len_d   = len_q - LEN_W'(1);
              cd_load = 1'b1;
              state_d = ST_PULSE;
            end
          end else if (pend_heal_q) begin
            clr_heal = 1'b1;
            if (len_q < MAX_LEN_L) begin
              upd_d   = CODE_HEAL;
              len_d   = len_q + LEN_W'(1);
              state_d = ST_PULSE;
            end
          end
        end
      end
      ST_PULSE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef DRAGON_REGEN_EN
  localparam logic [CNT_W-1:0] REGEN_TGT = CNT_W'(REGEN_FRAMES);

  logic [CNT_W-1:0] regen_q, regen_d;

  // Regen timer only runs while a heal could actually be applied.
  always_comb begin
    regen_d    = regen_q;
    regen_fire = 1'b0;
    if (cd_load || dead_q || inv_q || (len_q >= MAX_LEN_L)) begin
      regen_d = '0;
    end else if (vsync_rise) begin
      if (regen_q + CNT_W'(1) == REGEN_TGT) begin
        regen_fire = 1'b1;
        regen_d    = '0;
      end else begin
        regen_d = regen_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regen_q <= '0;
    end else begin
      regen_q <= regen_d;
    end
  end
`else
  assign regen_fire = 1'b0;
`endif

  // Request capture; a new event in the serving cycle re-arms the flag.
  always_comb begin
    pend_hit_d  = 1'b0;
    pend_heal_d = 1'b0;
    if (!dead_q) begin
      pend_hit_d  = (pend_hit_q & ~clr_hit) | (hit_evt & ~inv_q);
      pend_heal_d = (pend_heal_q & ~clr_heal) | heal_evt | regen_fire;
    end
  end

  // Immunity cooldown in frames; a fresh load beats the frame decrement.
  always_comb begin
    cd_d = cd_q;
    if (cd_load) begin
      cd_d = INV_LOAD;
    end else if (vsync_rise && (cd_q != '0)) begin
      cd_d = cd_q - CNT_W'(1);
    end
    inv_d = (cd_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      upd_q       <= CODE_NONE;
      len_q       <= '0;
      dead_q      <= 1'b0;
      inv_q       <= 1'b0;
      pend_heal_q <= 1'b0;
      pend_hit_q  <= 1'b0;
      cd_q        <= '0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_q       <= upd_d;
      len_q       <= len_d;
      dead_q      <= dead_d;
      inv_q       <= inv_d;
      pend_heal_q <= pend_heal_d;
      pend_hit_q  <= pend_hit_d;
      cd_q        <= cd_d;
      vsync_q     <= vsync;
    end
  end

  assign lengthUpdate = upd_q;
  assign length       = len_q;
  assign invuln       = inv_q;
  assign dead         = dead_q;

endmodule
